// File: rtl/sjr_method_caller.sv
// Drives one Synthesijer method call: preload four fields, request, track busy, capture return.
// Outputs are decoded from state so m_req and the field write enables drop as soon as reset asserts.
module sjr_method_caller #(
  parameter int DATA_WIDTH     = 32,
  parameter int STARTUP_CYCLES = 100,
  parameter int RISE_WINDOW    = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] arg0,
  input  logic [DATA_WIDTH-1:0] arg1,
  input  logic [DATA_WIDTH-1:0] arg2,
  input  logic [DATA_WIDTH-1:0] arg3,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] f0_in,
  output logic [DATA_WIDTH-1:0] f1_in,
  output logic [DATA_WIDTH-1:0] f2_in,
  output logic [DATA_WIDTH-1:0] f3_in,
  output logic                  f0_we,
  output logic                  f1_we,
  output logic                  f2_we,
  output logic                  f3_we,
  output logic                  m_req,
  input  logic                  m_busy,
  input  logic                  m_return,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic                  proto_err,
  output logic [31:0]           run_cycles
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_RUN,
    S_FIN
  } state_t;

  localparam logic [31:0] C_BOOT_LAST = 32'(STARTUP_CYCLES - 1);
  localparam logic [31:0] C_RISE_LAST = 32'(RISE_WINDOW - 1);
  localparam logic [31:0] C_TMO       = 32'(TIMEOUT_CYCLES);

  state_t                r_state;
  state_t                w_next;
  logic [31:0]           r_boot_cnt;
  logic [1:0]            r_load_k;
  logic [DATA_WIDTH-1:0] r_arg1;
  logic [DATA_WIDTH-1:0] r_arg2;
  logic [DATA_WIDTH-1:0] r_arg3;
  logic [DATA_WIDTH-1:0] r_fin0;
  logic [DATA_WIDTH-1:0] r_fin1;
  logic [DATA_WIDTH-1:0] r_fin2;
  logic [DATA_WIDTH-1:0] r_fin3;
  logic [31:0]           r_run;
  logic                  r_done;
  logic                  r_pass;
  logic                  r_tmo;
  logic                  r_perr;

  logic [31:0]           w_run_inc;
  logic                  w_calling;
  logic                  w_tmo_hit;
  logic                  w_rise_exp;
  logic [3:0]            w_we;
  logic                  w_req;
  logic                  w_ready;

  // run_cycles in REQ equals the number of m_req cycles already completed
  assign w_run_inc  = (r_run == 32'hFFFF_FFFF) ? r_run : r_run + 32'd1;
  assign w_calling  = (r_state == S_REQ) || (r_state == S_RUN);
  assign w_tmo_hit  = w_calling && (w_run_inc >= C_TMO);
  assign w_rise_exp = (r_state == S_REQ) && !m_busy && (r_run >= C_RISE_LAST);

  always_comb begin
    w_next  = r_state;
    w_we    = 4'b0000;
    w_req   = 1'b0;
    w_ready = 1'b0;
    case (r_state)
      S_BOOT: begin
        if (r_boot_cnt >= C_BOOT_LAST) w_next = S_IDLE;
      end
      S_IDLE: begin
        w_ready = 1'b1;
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_we[r_load_k] = 1'b1;
        if (r_load_k == 2'd3) w_next = S_REQ;
      end
      S_REQ: begin
        w_req = 1'b1;
        if (w_tmo_hit)       w_next = S_FIN;
        else if (m_busy)     w_next = S_RUN;
        else if (w_rise_exp) w_next = S_FIN;
      end
      S_RUN: begin
        if (w_tmo_hit || !m_busy) w_next = S_FIN;
      end
      S_FIN: begin
        w_next = S_IDLE;
      end
      default: w_next = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_boot_cnt <= 32'd0;
      r_load_k   <= 2'd0;
      r_arg1     <= '0;
      r_arg2     <= '0;
      r_arg3     <= '0;
      r_fin0     <= '0;
      r_fin1     <= '0;
      r_fin2     <= '0;
      r_fin3     <= '0;
      r_run      <= 32'd0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_tmo      <= 1'b0;
      r_perr     <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_boot_cnt <= r_boot_cnt + 32'd1;
        end
        S_IDLE: begin
          if (start) begin
            r_arg1   <= arg1;
            r_arg2   <= arg2;
            r_arg3   <= arg3;
            r_fin0   <= arg0;
            r_load_k <= 2'd0;
            r_run    <= 32'd0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_tmo    <= 1'b0;
            r_perr   <= 1'b0;
          end
        end
        S_LOAD: begin
          // each field word changes on the edge that opens its own write cycle
          r_load_k <= r_load_k + 2'd1;
          case (r_load_k)
            2'd0:    r_fin1 <= r_arg1;
            2'd1:    r_fin2 <= r_arg2;
            2'd2:    r_fin3 <= r_arg3;
            default: ;
          endcase
        end
        S_REQ, S_RUN: begin
          r_run <= w_run_inc;
          if (w_next == S_FIN) begin
            r_done <= 1'b1;
            if (w_tmo_hit)              r_tmo  <= 1'b1;
            else if (r_state == S_REQ)  r_perr <= 1'b1;
            else                        r_pass <= m_return;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready      = w_ready;
  assign m_req      = w_req;
  assign f0_we      = w_we[0];
  assign f1_we      = w_we[1];
  assign f2_we      = w_we[2];
  assign f3_we      = w_we[3];
  assign f0_in      = r_fin0;
  assign f1_in      = r_fin1;
  assign f2_in      = r_fin2;
  assign f3_in      = r_fin3;
  assign done       = r_done;
  assign pass       = r_pass;
  assign timeout    = r_tmo;
  assign proto_err  = r_perr;
  assign run_cycles = r_run;

endmodule

// File: tb/tb_sjr_method_caller.sv
// Scoreboard bench for sjr_method_caller with a small behavioural callee.
module tb_sjr_method_caller;

  localparam int DW      = 32;
  localparam int STARTUP = 100;
  localparam int RISE    = 4;
  localparam int TMO     = 50;

  localparam int CM_OFF  = 0;
  localparam int CM_NORM = 1;
  localparam int CM_PRE  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] arg0, arg1, arg2, arg3;
  logic          ready;
  logic [DW-1:0] f0_in, f1_in, f2_in, f3_in;
  logic          f0_we, f1_we, f2_we, f3_we;
  logic          m_req;
  logic          m_busy;
  logic          m_return;
  logic          done, pass, timeout, proto_err;
  logic [31:0]   run_cycles;

  always #5 clk = ~clk;

  sjr_method_caller #(
    .DATA_WIDTH    (DW),
    .STARTUP_CYCLES(STARTUP),
    .RISE_WINDOW   (RISE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .arg0      (arg0),
    .arg1      (arg1),
    .arg2      (arg2),
    .arg3      (arg3),
    .ready     (ready),
    .f0_in     (f0_in),
    .f1_in     (f1_in),
    .f2_in     (f2_in),
    .f3_in     (f3_in),
    .f0_we     (f0_we),
    .f1_we     (f1_we),
    .f2_we     (f2_we),
    .f3_we     (f3_we),
    .m_req     (m_req),
    .m_busy    (m_busy),
    .m_return  (m_return),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .proto_err (proto_err),
    .run_cycles(run_cycles)
  );

  typedef struct {
    logic [DW-1:0] a0, a1, a2, a3;
    logic          pass, tmo, perr;
    logic [31:0]   run;
    int            req;
  } res_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] dat;
  } wr_t;

  res_t res_q[$];
  wr_t  wr_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   req_cnt  = 0;
  logic done_q   = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard side: field writes and call results are popped as the DUT produces them
  always @(negedge clk) begin : p_mon
    logic [3:0]    we;
    logic [DW-1:0] d;
    wr_t           w;
    res_t          r;
    we = {f3_we, f2_we, f1_we, f0_we};
    if (we != 4'b0000) begin
      if (wr_q.size() == 0) begin
        check_eq("we_unexpected", {60'd0, we}, 64'd0);
      end else begin
        w = wr_q.pop_front();
        case (w.idx)
          0:       d = f0_in;
          1:       d = f1_in;
          2:       d = f2_in;
          default: d = f3_in;
        endcase
        check_eq("we_sel", {60'd0, we}, 64'd1 << w.idx);
        check_eq("we_dat", {32'd0, d}, {32'd0, w.dat});
      end
    end
    if (m_req) req_cnt++;
    if (done && !done_q) begin
      if (res_q.size() == 0) begin
        check_eq("done_unexpected", {63'd0, done}, 64'd0);
      end else begin
        r = res_q.pop_front();
        check_eq("pass",       {63'd0, pass},      {63'd0, r.pass});
        check_eq("timeout",    {63'd0, timeout},   {63'd0, r.tmo});
        check_eq("proto_err",  {63'd0, proto_err}, {63'd0, r.perr});
        check_eq("run_cycles", {32'd0, run_cycles}, {32'd0, r.run});
        check_eq("req_cycles", 64'(req_cnt),       64'(r.req));
        check_eq("f0_hold",    {32'd0, f0_in},     {32'd0, r.a0});
        check_eq("f3_hold",    {32'd0, f3_in},     {32'd0, r.a3});
      end
      req_cnt = 0;
    end
    done_q = done;
  end

  int   cal_mode  = CM_OFF;
  int   cal_phase = 0;
  int   cal_hold  = 0;
  int   cal_cnt   = 0;
  logic cal_ret   = 1'b0;

  // Callee: busy rises the cycle after req is seen, holds cal_hold cycles, return valid at the fall
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cal_mode == CM_NORM || cal_mode == CM_PRE) begin
        case (cal_phase)
          0: if (m_req) begin
               if (cal_mode == CM_PRE) begin
                 cal_cnt   = cal_hold;
                 cal_phase = 2;
               end else begin
                 cal_phase = 1;
               end
             end
          1: begin
               m_busy    = 1'b1;
               cal_cnt   = cal_hold;
               cal_phase = 2;
             end
          2: begin
               cal_cnt--;
               if (cal_cnt == 0) begin
                 m_busy    = 1'b0;
                 m_return  = cal_ret;
                 cal_phase = 3;
               end
             end
          default: ;
        endcase
      end
    end
  end

  task automatic do_call(input logic [DW-1:0] a0, a1, a2, a3, input int mode, input int hold,
                         input logic ret, input logic e_pass, e_tmo, e_perr,
                         input int e_run, input int e_req, input bit full);
    int   n;
    res_t r;
    wr_t  w;
    @(negedge clk);
    cal_mode  = mode;
    cal_hold  = hold;
    cal_ret   = ret;
    cal_phase = 0;
    m_return  = !ret;
    m_busy    = (mode == CM_PRE);
    n = 0;
    while (!ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait", {63'd0, ready}, 64'd1);
    w.idx = 0; w.dat = a0; wr_q.push_back(w);
    w.idx = 1; w.dat = a1; wr_q.push_back(w);
    w.idx = 2; w.dat = a2; wr_q.push_back(w);
    w.idx = 3; w.dat = a3; wr_q.push_back(w);
    if (full) begin
      r.a0 = a0; r.a1 = a1; r.a2 = a2; r.a3 = a3;
      r.pass = e_pass; r.tmo = e_tmo; r.perr = e_perr;
      r.run = 32'(e_run); r.req = e_req;
      res_q.push_back(r);
    end
    arg0 = a0; arg1 = a1; arg2 = a2; arg3 = a3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (full) begin
      n = 0;
      while (res_q.size() != 0 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check_eq("call_done", 64'(res_q.size()), 64'd0);
    end
  endtask

  // Enters with reset low; checks reset outputs, then the startup gate with an ignored start
  task automatic startup_check();
    repeat (6) @(negedge clk);
    check_eq("rst_ready",  {63'd0, ready},  64'd0);
    check_eq("rst_req",    {63'd0, m_req},  64'd0);
    check_eq("rst_we",     {60'd0, f3_we, f2_we, f1_we, f0_we}, 64'd0);
    check_eq("rst_flags",  {60'd0, done, pass, timeout, proto_err}, 64'd0);
    check_eq("rst_run",    {32'd0, run_cycles}, 64'd0);
    check_eq("rst_f1_in",  {32'd0, f1_in},  64'd0);
    reset = 1'b1;
    for (int i = 1; i <= STARTUP; i++) begin
      @(negedge clk);
      if (i == 50) start = 1'b1;
      if (i == 51) start = 1'b0;
      if (i == STARTUP - 1) check_eq("boot_ready_early", {63'd0, ready}, 64'd0);
      if (i == STARTUP)     check_eq("boot_ready",       {63'd0, ready}, 64'd1);
    end
    @(negedge clk);
    check_eq("start_not_queued", {63'd0, ready}, 64'd1);
    check_eq("boot_no_req",      64'(req_cnt),   64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset    = 1'b0;
    start    = 1'b0;
    arg0     = '0;
    arg1     = '0;
    arg2     = '0;
    arg3     = '0;
    m_busy   = 1'b0;
    m_return = 1'b0;

    startup_check();

    do_call(32'd1, 32'd2, 32'd3, 32'd4, CM_NORM, 10, 1'b1, 1'b1, 1'b0, 1'b0, 12, 2, 1'b1);
    do_call($urandom(), $urandom(), $urandom(), $urandom(), CM_NORM, 10, 1'b0,
            1'b0, 1'b0, 1'b0, 12, 2, 1'b1);
    do_call($urandom(), $urandom(), $urandom(), $urandom(), CM_PRE, 5, 1'b1,
            1'b1, 1'b0, 1'b0, 6, 1, 1'b1);
    do_call($urandom(), $urandom(), $urandom(), $urandom(), CM_NORM, 1000, 1'b1,
            1'b0, 1'b1, 1'b0, TMO, 2, 1'b1);
    do_call($urandom(), $urandom(), $urandom(), $urandom(), CM_OFF, 0, 1'b1,
            1'b0, 1'b0, 1'b1, RISE, RISE, 1'b1);
    do_call(32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'h7FFF_FFFF, CM_NORM, 3, 1'b1,
            1'b1, 1'b0, 1'b0, 5, 2, 1'b1);

    // Abort a call from inside RUN
    do_call($urandom(), $urandom(), $urandom(), $urandom(), CM_NORM, 40, 1'b1,
            1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    n = 0;
    while (!(m_busy && !m_req) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("midrun_reached", {63'd0, m_busy & ~m_req}, 64'd1);
    check_eq("midrun_wq_empty", 64'(wr_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    #1;
    reset    = 1'b0;
    cal_mode = CM_OFF;
    m_busy   = 1'b0;
    #1;
    check_eq("abort_req",   {63'd0, m_req}, 64'd0);
    check_eq("abort_ready", {63'd0, ready}, 64'd0);
    check_eq("abort_run",   {32'd0, run_cycles}, 64'd0);
    check_eq("abort_f0_in", {32'd0, f0_in}, 64'd0);
    res_q.delete();
    wr_q.delete();
    req_cnt = 0;

    startup_check();
    do_call(32'd1, 32'd2, 32'd3, 32'd4, CM_NORM, 10, 1'b1, 1'b1, 1'b0, 1'b0, 12, 2, 1'b1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
